usb_packet_tx: RTL and testbench

Transmit-side packetizer for the averager-to-USB path. It captures one result frame of NUM_BYTES bytes from the averagers (16 channels × 4 bytes by default) and emits it one byte per valid/ready handshake toward the USB byte interface. It computes CRC16-USB over the payload and appends the two CRC bytes. It is the mirror of the receive-side glue, which shifts in payload plus CRC and checks it.

---
 rtl/usb_packet_tx.sv | 133 +++++++++++++
 tb/tb_usb_packet_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_tx.sv
// Transmit packetizer: captures a NUM_BYTES frame and streams it over valid/ready.
// Define USB_TX_CRC_EN to append CRC16-USB (low byte first) after the payload.
module usb_packet_tx #(
  parameter int NUM_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

`ifdef USB_TX_CRC_EN
  typedef enum logic [1:0] {IDLE, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND_DATA} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] count, count_d;
  logic [7:0]    frame [NUM_BYTES];
  logic [7:0]    cur_byte;
  logic          capture;
  logic          done_d;

`ifdef USB_TX_CRC_EN
  logic [15:0] crc, crc_d;

  // Reflected CRC16-USB update, one byte folded in LSB-first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  assign capture  = (state == IDLE) && load;
  assign cur_byte = frame[count[IW-1:0]];
  assign busy     = (state != IDLE);

  always_comb begin
    state_d  = state;
    count_d  = count;
    done_d   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
`ifdef USB_TX_CRC_EN
    crc_d    = crc;
`endif
    unique case (state)
      IDLE: begin
        if (load) begin
          state_d = SEND_DATA;
          count_d = '0;
`ifdef USB_TX_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      SEND_DATA: begin
        tx_data  = cur_byte;
        tx_valid = 1'b1;
        if (tx_ready) begin
          count_d = count + CW'(1);
`ifdef USB_TX_CRC_EN
          crc_d   = crc16_byte(crc, cur_byte);
          if (count == LAST) state_d = SEND_CRC_LO;
`else
          if (count == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef USB_TX_CRC_EN
      SEND_CRC_LO: begin
        tx_data  = ~crc[7:0];
        tx_valid = 1'b1;
        if (tx_ready) state_d = SEND_CRC_HI;
      end
      SEND_CRC_HI: begin
        tx_data  = ~crc[15:8];
        tx_valid = 1'b1;
        if (tx_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
`ifdef USB_TX_CRC_EN
      crc   <= 16'hFFFF;
`endif
    end else begin
      state <= state_d;
      count <= count_d;
      done  <= done_d;
`ifdef USB_TX_CRC_EN
      crc   <= crc_d;
`endif
    end
  end

  // Frame register only changes on an accepted load, so data_in may move freely afterwards
  always_ff @(posedge clk) begin
    if (n_rst && capture) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        frame[k] <= data_in[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed bench for usb_packet_tx: a 9-byte and a 64-byte instance share one clock,
// and sel picks which one the stimulus drives and the checks observe.
module tb_usb_packet_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [71:0] MSG9 = 72'h39_38_37_36_35_34_33_32_31;

  logic          n_rst, load, tx_ready, sel;
  logic [71:0]   data9;
  logic [511:0]  data64;
  logic          load9, load64;
  logic [7:0]    txd9, txd64, txd_m;
  logic          txv9, txv64, busy9, busy64, done9, done64;
  logic          txv_m, busy_m, done_m;
  int            tests_run = 0;
  int            tests_failed = 0;

  assign load9  = load && !sel;
  assign load64 = load && sel;
  assign txd_m  = sel ? txd64  : txd9;
  assign txv_m  = sel ? txv64  : txv9;
  assign busy_m = sel ? busy64 : busy9;
  assign done_m = sel ? done64 : done9;

  usb_packet_tx #(.NUM_BYTES(9)) u_tx9 (
    .clk(clk), .n_rst(n_rst), .load(load9), .data_in(data9), .tx_ready(tx_ready),
    .tx_data(txd9), .tx_valid(txv9), .busy(busy9), .done(done9)
  );

  usb_packet_tx #(.NUM_BYTES(64)) u_tx64 (
    .clk(clk), .n_rst(n_rst), .load(load64), .data_in(data64), .tx_ready(tx_ready),
    .tx_data(txd64), .tx_valid(txv64), .busy(busy64), .done(done64)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [7:0] bytes[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bytes[i]) begin
      c ^= {8'h00, bytes[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // Entered at the negedge where byte 0 should be showing; leaves at the done negedge
  task automatic expect_frame(input logic [7:0] exp[$], input bit stall,
                              input int inject_at, input int abort_at);
    int         idx = 0;
    int         cycles = 0;
    bit         held = 1'b0;
    bit         injected = 1'b0;
    logic [7:0] prev = 8'h00;
    while (idx < exp.size() && cycles < 500) begin
      check("tx_valid", 32'(txv_m), 32'd1);
      check("busy", 32'(busy_m), 32'd1);
      check("done_mid_frame", 32'(done_m), 32'd0);
      check("tx_data", 32'(txd_m), 32'(exp[idx]));
      if (held) check("stall_hold", 32'(txd_m), 32'(prev));
      if (idx == abort_at) begin
        n_rst    = 1'b0;
        tx_ready = 1'b1;
        load     = 1'b0;
        @(negedge clk);
        return;
      end
      if (idx == inject_at && !injected) begin
        load     = 1'b1;
        data9    = ~data9;
        data64   = ~data64;
        injected = 1'b1;
      end else begin
        load = 1'b0;
      end
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev     = txd_m;
      held     = !tx_ready;
      if (tx_ready) idx++;
      @(negedge clk);
      cycles++;
    end
    load = 1'b0;
    check("frame_len", 32'(idx), 32'(exp.size()));
    check("done_pulse", 32'(done_m), 32'd1);
    check("busy_at_done", 32'(busy_m), 32'd0);
    check("valid_at_done", 32'(txv_m), 32'd0);
    check("data_at_done", 32'(txd_m), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  exp9[$];
    logic [7:0]  pay64[$];
    logic [7:0]  exp64[$];
    logic [15:0] crc64;

    n_rst = 1'b0; load = 1'b0; tx_ready = 1'b0; sel = 1'b0;
    data9 = MSG9; data64 = '0;
    for (int k = 0; k < 9; k++) exp9.push_back(8'(8'h31 + k));
`ifdef USB_TX_CRC_EN
    exp9.push_back(8'hC8);
    exp9.push_back(8'hB4);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data9", 32'(txd9), 32'd0);
    check("rst_valid9", 32'(txv9), 32'd0);
    check("rst_busy9", 32'(busy9), 32'd0);
    check("rst_done9", 32'(done9), 32'd0);
    check("rst_data64", 32'(txd64), 32'd0);
    check("rst_valid64", 32'(txv64), 32'd0);
    check("rst_busy64", 32'(busy64), 32'd0);
    check("rst_done64", 32'(done64), 32'd0);
    n_rst = 1'b1;

    // Check value "123456789" at full rate
    load = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_frame(exp9, 1'b0, -1, -1);

    // Back-to-back load in the done cycle, then stalls plus a load during byte 5
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_frame(exp9, 1'b1, 5, -1);
    tx_ready = 1'b1;
    @(negedge clk);
    check("no_extra_done", 32'(done_m), 32'd0);
    check("idle_after_frame", 32'(txv_m), 32'd0);
    data9 = MSG9;

    // Reset during the first CRC byte (last data byte without CRC)
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
`ifdef USB_TX_CRC_EN
    expect_frame(exp9, 1'b0, -1, 9);
`else
    expect_frame(exp9, 1'b0, -1, 8);
`endif
    check("abort_data", 32'(txd_m), 32'd0);
    check("abort_valid", 32'(txv_m), 32'd0);
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_done", 32'(done_m), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_m), 32'd0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_frame(exp9, 1'b0, -1, -1);

    // 64-byte incrementing payload, random backpressure then full rate
    sel = 1'b1;
    for (int k = 0; k < 64; k++) begin
      data64[8*k +: 8] = 8'(k);
      pay64.push_back(8'(k));
    end
    exp64 = pay64;
`ifdef USB_TX_CRC_EN
    crc64 = crc_model(pay64);
    exp64.push_back(crc64[7:0]);
    exp64.push_back(crc64[15:8]);
`else
    crc64 = 16'h0000;
`endif
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_frame(exp64, 1'b1, -1, -1);
    tx_ready = 1'b1;
    @(negedge clk);
    check("no_extra_byte", 32'(txv_m), 32'd0);
    check("no_extra_done64", 32'(done_m), 32'd0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    expect_frame(exp64, 1'b0, -1, -1);
    @(negedge clk);
    check("final_idle_valid", 32'(txv_m), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
